// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART two-byte command assembler:
//   - state_e             : command FSM states (high byte / low byte phase)
//   - TIMEOUT_CYC_DEFAULT : default inter-byte timeout in clk cycles
//                           (20 ms at 50 MHz)
//   - timer_width()       : counter width able to hold 0..TIMEOUT_CYC
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 1_000_000;

  typedef enum logic {
    IDLE     = 1'b0,  // waiting for the high (first) byte
    WAIT_LOW = 1'b1   // high byte held, waiting for the low (second) byte
  } state_e;

  // ceil(log2(cyc+1)), never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage : uart_cmd_pkg

// File: rtl/cmd_timer.sv
// -----------------------------------------------------------------------------
// cmd_timer
// Inter-byte timeout counter. Counts enabled cycles from zero, saturates at
// TIMEOUT_CYC (never wraps) and flags the terminal count TIMEOUT_CYC-1.
//
// Ports
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset (count -> 0)
//   clr_i  : clear count to zero (has priority over en_i)
//   en_i   : advance count by one this cycle
//   tc_o   : count currently equals TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module cmd_timer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = timer_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every combinational output gets its default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNT_TC);

endmodule : cmd_timer

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
// Assembles a 16-bit command from two consecutive UART bytes ({first, second}).
// A partial command is discarded if the second byte does not arrive within
// TIMEOUT_CYC cycles of the first.
//
// Ports
//   clk          : 50 MHz system clock, rising edge
//   rst_n        : synchronous active-low reset
//   rx_rdy       : receiver has a byte; stays high until cleared
//   rx_data      : received byte, valid while rx_rdy is high
//   clr_rx_rdy   : one-cycle pulse acknowledging an accepted byte
//   clr_cmd_rdy  : consumer acknowledge, knocks down cmd_rdy
//   cmd          : assembled command {high byte, low byte}
//   cmd_rdy      : cmd holds a complete, unconsumed command
//   timeout_err  : one-cycle pulse when a partial command is discarded
// -----------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        timeout_err
);

  state_e     state_q, state_d;
  logic [7:0] cmd_hi_q, cmd_hi_d;
  logic [7:0] cmd_lo_q, cmd_lo_d;
  logic       cmd_rdy_q, cmd_rdy_d;
  // Set on every capture and held until rx_rdy is seen low. The receiver
  // drops rx_rdy at least one edge after our clear pulse, so without this a
  // still-high rx_rdy would capture the same byte a second time.
  logic       hold_q, hold_d;

  logic       accept;
  logic       tmr_clr;
  logic       tmr_en;
  logic       tmr_tc;

  // Gating with rst_n keeps clr_rx_rdy quiet while reset is asserted.
  assign accept = rx_rdy && !hold_q && rst_n;

  always_comb begin
    state_d     = state_q;
    cmd_hi_d    = cmd_hi_q;
    cmd_lo_d    = cmd_lo_q;
    cmd_rdy_d   = cmd_rdy_q;
    hold_d      = hold_q && rx_rdy;
    clr_rx_rdy  = 1'b0;
    timeout_err = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    // Consumer acknowledge; a low-byte capture below overrides it.
    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_hi_d   = rx_data;
          clr_rx_rdy = 1'b1;
          cmd_rdy_d  = 1'b0;  // a new high byte invalidates any pending command
          tmr_clr    = 1'b1;
          hold_d     = 1'b1;
          state_d    = WAIT_LOW;
        end
      end

      WAIT_LOW: begin
        if (accept) begin
          // A byte on the terminal-count cycle still completes the command.
          cmd_lo_d   = rx_data;
          clr_rx_rdy = 1'b1;
          cmd_rdy_d  = 1'b1;
          hold_d     = 1'b1;
          state_d    = IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            // Drop the partial command; cmd_hi_q stays stale and cmd_rdy
            // keeps whatever value it already had.
            timeout_err = rst_n;
            state_d     = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_hi_q  <= 8'h00;
      cmd_lo_q  <= 8'h00;
      cmd_rdy_q <= 1'b0;
      hold_q    <= 1'b0;  // a pending byte is taken right after release
    end else begin
      state_q   <= state_d;
      cmd_hi_q  <= cmd_hi_d;
      cmd_lo_q  <= cmd_lo_d;
      cmd_rdy_q <= cmd_rdy_d;
      hold_q    <= hold_d;
    end
  end

  cmd_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cmd_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  assign cmd     = {cmd_hi_q, cmd_lo_q};
  assign cmd_rdy = cmd_rdy_q;

endmodule : uart_cmd_ctrl
